// File: rtl/carry_select_seq_adder_ctrl_if.sv
// Handshake bundle for the sequential carry-select adder:
// operand side (in_*) and result side (out_*, sum, flags).
interface carry_select_seq_adder_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/carry_select_seq_adder_ctrl.sv
// Sequencer stepping one SLICE-bit carry-select stage over a
// WIDTH-bit add, one slice per cycle, with in/out handshakes.
module carry_select_seq_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic clk,
    input  logic rst_n,
    carry_select_seq_adder_ctrl_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;

    logic             accept;
    logic             step;
    logic             last;
    int               base;
    logic [SLICE-1:0] a_k;
    logic [SLICE-1:0] b_k;
    logic [SLICE:0]   s0;
    logic [SLICE:0]   s1;
    logic [SLICE:0]   sel;
    logic             c_msb;

    // Both carry hypotheses for the current slice; the registered
    // carry picks one, as in a 2:1 carry-select stage.
    always_comb begin
        base  = int'(k_q) * SLICE;
        a_k   = a_q[base +: SLICE];
        b_k   = b_q[base +: SLICE];
        s0    = {1'b0, a_k} + {1'b0, b_k};
        s1    = s0 + 1'b1;
        sel   = carry_q ? s1 : s0;
        c_msb = sel[SLICE-1] ^ a_k[SLICE-1] ^ b_k[SLICE-1];
        last  = (k_q == KW'(NSLICE - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath enables.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and slice-by-slice sum/carry update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                carry_q <= bus.cin;
                k_q     <= '0;
            end
            if (step) begin
                sum_q[base +: SLICE] <= sel[SLICE-1:0];
                carry_q <= sel[SLICE];
                if (last) begin
                    cout_q <= sel[SLICE];
                    ovf_q  <= c_msb ^ sel[SLICE];
                    k_q    <= '0;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/carry_select_seq_adder_ctrl.md
Name: carry_select_seq_adder_ctrl

Overview:
Sequencer that drives a single SLICE-bit carry-select adder stage over WIDTH-bit operands across multiple cycles. Each cycle it forms both carry hypotheses for one slice, the carry_zero result and the carry_one result. The registered carry chooses between them, exactly as the 2:1 carry-select mux stage does. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand and sum width in bits; must be an integer multiple of SLICE.
SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE >= 1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand set valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered sum.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  signed overflow (two's complement).
busy  output  1  high in RUN or DONE.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. State resets to IDLE, slice index k=0, carry register=0.
- States: IDLE, RUN, DONE. All outputs are decoded from registered state or driven from registers. There are no combinational paths from inputs to outputs.
- IDLE: in_ready=1.
  - On in_valid&&in_ready at an edge: capture a, b, cin into operand registers, set carry_reg=cin, set k=0, go to RUN.
  - in_valid low: stay in IDLE.
- RUN: in_ready=0. Each cycle, operating on slice k (bits k*SLICE+SLICE-1 : k*SLICE):
  - s0 = a_k+b_k+0 and s1 = a_k+b_k+1, each (SLICE+1) bits.
  - Select s1 if carry_reg=1, else s0.
  - Write the low SLICE bits into sum_reg slice k. carry_reg <= the selected bit SLICE.
  - k==NSLICE-1: also capture cout = selected carry, and ovf = (carry into bit WIDTH-1) XOR cout, taken from the selected hypothesis. Go to DONE and reset k to 0.
  - Otherwise k <= k+1.
- DONE: out_valid=1. sum, cout and ovf are held stable until the transfer.
  - On out_valid&&out_ready at an edge, go to IDLE.
  - out_ready low holds DONE indefinitely.
- Latency: out_valid rises NSLICE cycles after the accept edge. Minimum period between accepts is NSLICE+2 cycles (RUN NSLICE, DONE at least 1, IDLE 1).
- No bypass: in_ready=0 in DONE, so a new operand cannot be accepted in the same cycle as the result transfer.
- Operand inputs are sampled only at the accept edge. Later changes to a, b or cin have no effect. in_valid while in_ready=0 is ignored and not queued.
- The sum register is overwritten slice by slice during RUN. The sum output is valid only while out_valid=1.
- NSLICE=1: RUN lasts exactly 1 cycle.
- Arithmetic is modulo 2^WIDTH.
- Reset mid-RUN or mid-DONE: the operation is aborted and its result discarded. Outputs go to their reset values immediately.

Test Plan:
All scenarios use WIDTH=32, SLICE=8 unless stated.
1. Reset: assert rst_n=0 mid-cycle -> outputs immediately in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
2. Basic add: a=0x000000FF, b=0x00000001, cin=0 -> out_valid 4 cycles after accept; sum=0x00000100, cout=0, ovf=0.
3. Full ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0, with the carry selected through all 4 slices.
4. Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum, cout, ovf stable, in_ready=0, new operands ignored. Then out_ready=1 -> IDLE next cycle and the new operands are accepted one cycle later.
6. Abort and SLICE=32 variant: pull rst_n low during RUN at k=2 -> out_valid never asserts and in_ready=1 after release; the next op 0x12345678+0x11111111 gives 0x23456789. With SLICE=32, the same op gives the same result 1 cycle after accept.
